// File: rtl/snake_pkg.sv
// Shared types and grid helpers for the snake-game blocks.
package snake_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WON  = 2'd2
  } placer_state_t;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } rc_t;

  // Row-major split of a linear cell index.
  function automatic rc_t idx_to_rc(input int unsigned idx, input int unsigned cols);
    rc_t rc;
    rc.row = 8'(idx / cols);
    rc.col = 8'(idx % cols);
    return rc;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11), loaded with seed on reset.
module lfsr16 (
  input  logic        Clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Right-shifting Galois step: feedback bit XORs the tap mask.
  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (reset) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/food_placer.sv
// Food placement, snake length, win detection and BCD score for the snake game.
module food_placer
  import snake_pkg::*;
#(
  parameter int          ROWS     = DEF_ROWS,
  parameter int          COLS     = DEF_COLS,
  parameter int          LEN_INIT = 2,
  parameter int          INIT_ROW = 3,
  parameter int          INIT_COL = 2,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                           Clock,
  input  logic                           reset,
  input  logic                           hit_score,
  input  logic [ROWS-1:0][COLS-1:0]      occupied_array,
  output logic [ROWS-1:0][COLS-1:0]      score_array,
  output logic [$clog2(ROWS*COLS+1)-1:0] snake_length,
  output logic                           busy,
  output logic                           winGame,
  output logic [3:0]                     digit_1,
  output logic [3:0]                     digit_10
);

  localparam int CELLS    = ROWS * COLS;
  localparam int IW       = $clog2(CELLS);
  localparam int LW       = $clog2(CELLS + 1);
  localparam int INIT_IDX = INIT_ROW * COLS + INIT_COL;
  localparam logic [CELLS-1:0] INIT_SCORE = {{(CELLS-1){1'b0}}, 1'b1} << INIT_IDX;

  placer_state_t    state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CELLS-1:0] score_q, score_d;
  logic [3:0]       d1_q, d1_d, d10_q, d10_d;
  logic             busy_q, busy_d, win_q, win_d;

  logic [15:0]      lfsr_s;
  logic [CELLS-1:0] occ_flat_s;
  logic [IW+1:0]    diff_s;
  logic [IW-1:0]    idx0_s;
  logic [LW-1:0]    len_inc_s;
  logic             unused_lfsr_s;

  lfsr16 u_lfsr (
    .Clock (Clock),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_s)
  );

  assign occ_flat_s    = occupied_array;
  assign unused_lfsr_s = ^lfsr_s[15:IW];
  assign len_inc_s     = len_q + LW'(1);

  // Fold the raw LFSR slice into [0, CELLS) with a single conditional subtract.
  always_comb begin
    diff_s = {2'b00, lfsr_s[IW-1:0]} - (IW+2)'(CELLS);
    if (!diff_s[IW+1]) begin
      idx0_s = diff_s[IW-1:0];
    end else begin
      idx0_s = lfsr_s[IW-1:0];
    end
  end

  // Placement FSM with length and score bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    score_d = score_q;
    d1_d    = d1_q;
    d10_d   = d10_q;
    case (state_q)
      IDLE: begin
        if (hit_score) begin
          len_d = len_inc_s;
          if (d1_q != 4'd9) begin
            d1_d = d1_q + 4'd1;
          end else if (d10_q != 4'd9) begin
            d1_d  = 4'd0;
            d10_d = d10_q + 4'd1;
          end else begin
            d1_d = d1_q;
          end
          score_d = '0;
          if (len_inc_s == LW'(CELLS)) begin
            state_d = WON;
          end else begin
            state_d = SCAN;
            idx_d   = idx0_s;
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!occ_flat_s[idx_q]) begin
          score_d        = '0;
          score_d[idx_q] = 1'b1;
          state_d        = IDLE;
        end else if (cnt_q == IW'(CELLS - 1)) begin
          score_d = '0;
          state_d = WON;
        end else begin
          idx_d = (idx_q == IW'(CELLS - 1)) ? '0 : idx_q + IW'(1);
          cnt_d = cnt_q + IW'(1);
        end
      end
      WON: begin
        score_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCAN);
    win_d  = (state_d == WON);
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= LW'(LEN_INIT);
      score_q <= INIT_SCORE;
      d1_q    <= 4'd0;
      d10_q   <= 4'd0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      score_q <= score_d;
      d1_q    <= d1_d;
      d10_q   <= d10_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
    end
  end

  assign score_array  = score_q;
  assign snake_length = len_q;
  assign busy         = busy_q;
  assign winGame      = win_q;
  assign digit_1      = d1_q;
  assign digit_10     = d10_q;

endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer: table vectors, corner sequences and random scans.
module tb_food_placer;
  import snake_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             hit8 = 1'b0, hit15 = 1'b0;
  logic [7:0][7:0]  occ8 = '0, score8;
  logic [4:0][2:0]  occ15 = '0, score15;
  logic [6:0]       len8;
  logic [3:0]       len15;
  logic             busy8, win8, busy15, win15;
  logic [3:0]       d1_8, d10_8, d1_15, d10_15;

  food_placer dut8 (
    .Clock(clk), .reset(reset), .hit_score(hit8), .occupied_array(occ8),
    .score_array(score8), .snake_length(len8), .busy(busy8), .winGame(win8),
    .digit_1(d1_8), .digit_10(d10_8)
  );

  food_placer #(.ROWS(5), .COLS(3)) dut15 (
    .Clock(clk), .reset(reset), .hit_score(hit15), .occupied_array(occ15),
    .score_array(score15), .snake_length(len15), .busy(busy15), .winGame(win15),
    .digit_1(d1_15), .digit_10(d10_15)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] lfsr_m;
  int eaten;
  int len_m;

  typedef struct {
    logic [63:0] occ;
    int          idx0;
    int          food;
    int          busy_cycles;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock edge; the reference LFSR follows the free-running sequence from SEED.
  task automatic tick();
    @(posedge clk);
    if (reset) lfsr_m = SEED;
    else lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    #1;
  endtask

  function automatic int idx0_of(input logic [15:0] l, input int cells);
    int raw;
    raw = int'(l) % (1 << $clog2(cells));
    if (raw >= cells) raw = raw - cells;
    return raw;
  endfunction

  function automatic logic [63:0] food8(input int idx);
    logic [7:0][7:0] e;
    rc_t rc;
    e = '0;
    rc = idx_to_rc(idx, 8);
    e[rc.row[2:0]][rc.col[2:0]] = 1'b1;
    return e;
  endfunction

  // Walk the grid circularly from start; first free cell wins.
  task automatic predict(input logic [63:0] occ, input int start,
                         output int food, output int busy_cycles, output bit won);
    won = 1'b1; food = -1; busy_cycles = 64;
    for (int k = 0; k < 64; k++) begin
      if (!occ[(start + k) % 64]) begin
        food = (start + k) % 64; busy_cycles = k + 1; won = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    eaten = 0;
    len_m = 2;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_score"}, score8, food8(3 * 8 + 2));
    check({tag, "_len"}, 64'(len8), 64'd2);
    check({tag, "_busy"}, 64'(busy8), 64'd0);
    check({tag, "_win"}, 64'(win8), 64'd0);
    check({tag, "_digits"}, 64'({d10_8, d1_8}), 64'h00);
  endtask

  task automatic hit8_run(input string tag, input logic [63:0] occ, input int target,
                          input int exp_food, input int exp_busy, input bit pester);
    int guard, start, food, bc, cnt;
    bit won;
    guard = 0;
    occ8 = occ;
    if (target >= 0) begin
      while (idx0_of(lfsr_m, 64) != target && guard < 5000) begin
        tick(); guard++;
      end
      if (guard >= 5000) begin
        n_checks++; n_errors++;
        $display("FAIL %s_seek: idx0 %0d never reached", tag, target);
      end
    end
    start = idx0_of(lfsr_m, 64);
    predict(occ, start, food, bc, won);
    if (exp_food >= 0) food = exp_food;
    if (exp_busy >= 0) bc = exp_busy;
    hit8 = 1'b1;
    tick();
    hit8 = 1'b0;
    eaten++;
    len_m++;
    check({tag, "_busy_rise"}, 64'(busy8), 64'd1);
    cnt = 0;
    while (busy8 && cnt < 200) begin
      cnt++;
      hit8 = pester && (cnt % 3 == 0);
      tick();
      hit8 = 1'b0;
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(bc));
    check({tag, "_score"}, score8, won ? 64'd0 : food8(food));
    check({tag, "_win"}, 64'(win8), 64'(won));
    check({tag, "_len"}, 64'(len8), 64'(len_m));
    check({tag, "_digits"}, 64'({d10_8, d1_8}), 64'(((eaten / 10) << 4) | (eaten % 10)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    logic [4:0][2:0] e15;
    int guard;
    logic [63:0] occ;

    tbl[0] = '{64'h0000_0000_0000_0000,  5,  5, 1};
    tbl[1] = '{64'h0000_0000_0000_03E0,  5, 10, 6};
    tbl[2] = '{64'h8000_0000_0000_0000, 63,  0, 2};
    tbl[3] = '{64'hC000_0000_0000_000F, 62,  4, 7};

    lfsr_m = SEED;
    do_reset();
    check_reset_state("reset");
    e15 = '0; e15[3][2] = 1'b1;
    check("r15_reset_score", 64'(score15), 64'(e15));

    // 5x3 grid: raw slice 15 must fold to cell 0, raw 7 stays at 7 ([2][1]).
    for (int j = 0; j < 2; j++) begin
      guard = 0;
      while (int'(lfsr_m[3:0]) != (j == 0 ? 15 : 7) && guard < 5000) begin
        tick(); guard++;
      end
      hit15 = 1'b1; tick(); hit15 = 1'b0;
      check("r15_busy", 64'(busy15), 64'd1);
      tick();
      check("r15_busy_fall", 64'(busy15), 64'd0);
      e15 = '0;
      if (j == 0) e15[0][0] = 1'b1; else e15[2][1] = 1'b1;
      check("r15_food", 64'(score15), 64'(e15));
      check("r15_len", 64'(len15), 64'(3 + j));
    end

    for (int i = 0; i < 4; i++)
      hit8_run($sformatf("vec%0d", i), tbl[i].occ, tbl[i].idx0, tbl[i].food, tbl[i].busy_cycles, 1'b0);

    // Long scan with hits every third cycle: only the first hit counts.
    hit8_run("pester", 64'h0000_00FF_FFFF_FFFF, 0, 40, 41, 1'b1);

    for (int i = 0; i < 10; i++) begin
      occ = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      repeat ($urandom_range(0, 4)) tick();
      hit8_run($sformatf("rnd%0d", i), occ, -1, -1, -1, 1'b0);
    end

    hit8_run("allocc", {64{1'b1}}, -1, -1, -1, 1'b0);
    hit8 = 1'b1; tick(); hit8 = 1'b0; tick();
    check("won_len_hold", 64'(len8), 64'(len_m));
    check("won_digits_hold", 64'({d10_8, d1_8}), 64'(((eaten / 10) << 4) | (eaten % 10)));
    check("won_sticky", 64'(win8), 64'd1);
    check("won_busy", 64'(busy8), 64'd0);

    do_reset();
    check_reset_state("reset2");

    // Reset in the middle of a scan.
    occ8 = {64{1'b1}};
    hit8 = 1'b1; tick(); hit8 = 1'b0;
    tick(); tick();
    check("midscan_busy", 64'(busy8), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    eaten = 0; len_m = 2;
    check_reset_state("midscan_reset");

    // Fill to CELLS-1 on an empty grid, then the next hit wins directly.
    while (len_m < 63) hit8_run("fill", 64'd0, -1, -1, -1, 1'b0);
    hit8 = 1'b1; tick(); hit8 = 1'b0;
    eaten++; len_m++;
    check("fill_win", 64'(win8), 64'd1);
    check("fill_busy", 64'(busy8), 64'd0);
    check("fill_score", score8, 64'd0);
    check("fill_len", 64'(len8), 64'd64);
    check("fill_digits", 64'({d10_8, d1_8}), 64'h62);
    hit8 = 1'b1; tick(); hit8 = 1'b0;
    check("fill_len_hold", 64'(len8), 64'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
